// File: rtl/spi_burst_receiver.sv
// Purpose : oversampling SPI slave receiver, all four modes, multi-word bursts per chip-select frame.
// Latency : word outputs 3 spiClk edges after the sampling sck edge; frameDone 4 edges after cs release.
// Backpressure: none, because the SPI master cannot be stalled; words beyond maxWords are dropped and flagged.
//
// Ports:
//   spiClk, nRst            receiver clock, synchronous active-low reset
//   sck, sdi, cs            asynchronous SPI pins, synchronised internally
//   writeData/writeEnable   last completed word and its one-cycle strobe
//   wordIndex               0-based position of writeData within the frame
//   busy                    frame in progress (ACTIVE state)
//   frameDone/frameError    end-of-frame pulse; error if the frame ended mid-word
//   wordCount               accepted words in the finished frame, held
//   overrun                 sticky: a word beyond maxWords arrived in this frame
module spi_burst_receiver #(
   parameter int wordBits     = 8,
   parameter int maxWords     = 4,
   parameter int spiMode      = 0,
   parameter int msbFirst     = 1,
   parameter int csActiveHigh = 1
) (
   input  logic                                                spiClk,
   input  logic                                                nRst,
   input  logic                                                sck,
   input  logic                                                sdi,
   input  logic                                                cs,
   output logic [wordBits-1:0]                                 writeData,
   output logic                                                writeEnable,
   output logic [((maxWords > 1) ? $clog2(maxWords) : 1)-1:0]  wordIndex,
   output logic                                                busy,
   output logic                                                frameDone,
   output logic                                                frameError,
   output logic [$clog2(maxWords+1)-1:0]                       wordCount,
   output logic                                                overrun
);

   localparam int   BCW         = $clog2(wordBits + 1);
   localparam int   WCW         = $clog2(maxWords + 2);   // word counter saturates at maxWords+1
   localparam int   WIW         = (maxWords > 1) ? $clog2(maxWords) : 1;
   localparam int   WNW         = $clog2(maxWords + 1);
   localparam logic CPOL        = (spiMode >= 2);
   localparam logic SAMPLE_RISE = (spiMode == 0) || (spiMode == 3);
   localparam logic CS_ACT      = (csActiveHigh != 0);

   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

   state_t state_q, state_d;

   // [0],[1] synchroniser, [2] delay stage for edge detection
   logic [2:0]          sck_sync_q, sck_sync_d;
   logic [2:0]          cs_sync_q,  cs_sync_d;
   logic [2:0]          sdi_sync_q, sdi_sync_d;

   logic [wordBits-1:0] shift_q, shift_d;
   logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0]      word_cnt_q, word_cnt_d;
   logic [wordBits-1:0] wdata_q, wdata_d;
   logic                we_q, we_d;
   logic [WIW-1:0]      widx_q, widx_d;
   logic                fd_q, fd_d;
   logic                fe_q, fe_d;
   logic [WNW-1:0]      wcount_q, wcount_d;
   logic                ovr_q, ovr_d;

   logic                sample_edge, cs_now, cs_prev, cs_start, cs_end;
   logic [BCW-1:0]      bit_cnt_inc;
   logic [wordBits-1:0] shift_in;

   always_comb begin
      sck_sync_d  = {sck_sync_q[1:0], sck};
      cs_sync_d   = {cs_sync_q[1:0],  cs};
      sdi_sync_d  = {sdi_sync_q[1:0], sdi};

      sample_edge = SAMPLE_RISE ? ( sck_sync_q[1] & ~sck_sync_q[2])
                                : (~sck_sync_q[1] &  sck_sync_q[2]);
      cs_now      = (cs_sync_q[1] == CS_ACT);
      cs_prev     = (cs_sync_q[2] == CS_ACT);
      cs_start    = cs_now & ~cs_prev;
      cs_end      = ~cs_now & cs_prev;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_start) state_d = ACTIVE;
         ACTIVE:  if (cs_end)   state_d = DRAIN;
         DRAIN:                 state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   always_ff @(posedge spiClk) begin
      if (!nRst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Datapath. The delayed sdi stage pairs with the old sck level, so the bit
   // taken is the one present just before the sampling edge was seen.
   always_comb begin
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      word_cnt_d  = word_cnt_q;
      wdata_d     = wdata_q;
      we_d        = 1'b0;
      widx_d      = widx_q;
      fd_d        = 1'b0;
      fe_d        = 1'b0;
      wcount_d    = wcount_q;
      ovr_d       = ovr_q;
      bit_cnt_inc = bit_cnt_q + BCW'(1);
      shift_in    = (msbFirst != 0) ? {shift_q[wordBits-2:0], sdi_sync_q[2]}
                                    : {sdi_sync_q[2], shift_q[wordBits-1:1]};

      case (state_q)
         IDLE: begin
            if (cs_start) begin
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               ovr_d      = 1'b0;
            end
         end
         ACTIVE: begin
            // cs release wins over a coincident sampling edge: the bit is discarded
            if (!cs_end && sample_edge) begin
               shift_d = shift_in;
               if (bit_cnt_inc == BCW'(wordBits)) begin
                  bit_cnt_d = '0;
                  if (word_cnt_q < WCW'(maxWords)) begin
                     wdata_d = shift_in;
                     widx_d  = word_cnt_q[WIW-1:0];
                     we_d    = 1'b1;
                  end else begin
                     ovr_d   = 1'b1;
                  end
                  if (word_cnt_q != WCW'(maxWords + 1))
                     word_cnt_d = word_cnt_q + WCW'(1);
               end else begin
                  bit_cnt_d = bit_cnt_inc;
               end
            end
         end
         DRAIN: begin
            fd_d     = 1'b1;
            fe_d     = (bit_cnt_q != '0);
            wcount_d = (word_cnt_q > WCW'(maxWords)) ? WNW'(maxWords) : word_cnt_q[WNW-1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge spiClk) begin
      if (!nRst) begin
         // cs chain parks at the active level so a cs held through reset yields no start edge
         sck_sync_q <= {3{CPOL}};
         cs_sync_q  <= {3{CS_ACT}};
         sdi_sync_q <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         widx_q     <= '0;
         fd_q       <= 1'b0;
         fe_q       <= 1'b0;
         wcount_q   <= '0;
         ovr_q      <= 1'b0;
      end else begin
         sck_sync_q <= sck_sync_d;
         cs_sync_q  <= cs_sync_d;
         sdi_sync_q <= sdi_sync_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         widx_q     <= widx_d;
         fd_q       <= fd_d;
         fe_q       <= fe_d;
         wcount_q   <= wcount_d;
         ovr_q      <= ovr_d;
      end
   end

   assign writeData   = wdata_q;
   assign writeEnable = we_q;
   assign wordIndex   = widx_q;
   assign busy        = (state_q == ACTIVE);
   assign frameDone   = fd_q;
   assign frameError  = fe_q;
   assign wordCount   = wcount_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_spi_burst_receiver.sv
// Purpose : self-checking bench for spi_burst_receiver across five parameter sets.
// Latency : checks word latency (3 edges) and frame-end latency (4 edges).
// Backpressure: not applicable; the bench drives SPI pins directly.
module tb_spi_burst_receiver;

   localparam int N = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [N-1:0] nrst_v, sck_v, sdi_v, cs_v;
   logic [N-1:0] we_v, busy_v, fd_v, fe_v, ov_v;

   logic [7:0]  wd0, wd2, wd3, wd4;
   logic [15:0] wd1;
   logic [1:0]  wi0, wi1, wi2, wi4;
   logic [0:0]  wi3;
   logic [2:0]  wc0, wc1, wc2, wc4;
   logic [1:0]  wc3;

   logic [31:0] wd_x [N];
   logic [31:0] wi_x [N];
   logic [31:0] wc_x [N];

   assign wd_x[0] = 32'(wd0); assign wi_x[0] = 32'(wi0); assign wc_x[0] = 32'(wc0);
   assign wd_x[1] = 32'(wd1); assign wi_x[1] = 32'(wi1); assign wc_x[1] = 32'(wc1);
   assign wd_x[2] = 32'(wd2); assign wi_x[2] = 32'(wi2); assign wc_x[2] = 32'(wc2);
   assign wd_x[3] = 32'(wd3); assign wi_x[3] = 32'(wi3); assign wc_x[3] = 32'(wc3);
   assign wd_x[4] = 32'(wd4); assign wi_x[4] = 32'(wi4); assign wc_x[4] = 32'(wc4);

   // per-instance configuration used by the stimulus tasks
   int cfg_mode [N] = '{0, 3, 1, 0, 2};
   int cfg_bits [N] = '{8, 16, 8, 8, 8};
   int cfg_msb  [N] = '{1, 0, 1, 1, 1};
   int cfg_csh  [N] = '{1, 1, 1, 1, 0};

   spi_burst_receiver #(.wordBits(8), .maxWords(4), .spiMode(0), .msbFirst(1), .csActiveHigh(1)) u0 (
      .spiClk(clk), .nRst(nrst_v[0]), .sck(sck_v[0]), .sdi(sdi_v[0]), .cs(cs_v[0]),
      .writeData(wd0), .writeEnable(we_v[0]), .wordIndex(wi0), .busy(busy_v[0]),
      .frameDone(fd_v[0]), .frameError(fe_v[0]), .wordCount(wc0), .overrun(ov_v[0]));

   spi_burst_receiver #(.wordBits(16), .maxWords(4), .spiMode(3), .msbFirst(0), .csActiveHigh(1)) u1 (
      .spiClk(clk), .nRst(nrst_v[1]), .sck(sck_v[1]), .sdi(sdi_v[1]), .cs(cs_v[1]),
      .writeData(wd1), .writeEnable(we_v[1]), .wordIndex(wi1), .busy(busy_v[1]),
      .frameDone(fd_v[1]), .frameError(fe_v[1]), .wordCount(wc1), .overrun(ov_v[1]));

   spi_burst_receiver #(.wordBits(8), .maxWords(4), .spiMode(1), .msbFirst(1), .csActiveHigh(1)) u2 (
      .spiClk(clk), .nRst(nrst_v[2]), .sck(sck_v[2]), .sdi(sdi_v[2]), .cs(cs_v[2]),
      .writeData(wd2), .writeEnable(we_v[2]), .wordIndex(wi2), .busy(busy_v[2]),
      .frameDone(fd_v[2]), .frameError(fe_v[2]), .wordCount(wc2), .overrun(ov_v[2]));

   spi_burst_receiver #(.wordBits(8), .maxWords(2), .spiMode(0), .msbFirst(1), .csActiveHigh(1)) u3 (
      .spiClk(clk), .nRst(nrst_v[3]), .sck(sck_v[3]), .sdi(sdi_v[3]), .cs(cs_v[3]),
      .writeData(wd3), .writeEnable(we_v[3]), .wordIndex(wi3), .busy(busy_v[3]),
      .frameDone(fd_v[3]), .frameError(fe_v[3]), .wordCount(wc3), .overrun(ov_v[3]));

   spi_burst_receiver #(.wordBits(8), .maxWords(4), .spiMode(2), .msbFirst(1), .csActiveHigh(0)) u4 (
      .spiClk(clk), .nRst(nrst_v[4]), .sck(sck_v[4]), .sdi(sdi_v[4]), .cs(cs_v[4]),
      .writeData(wd4), .writeEnable(we_v[4]), .wordIndex(wi4), .busy(busy_v[4]),
      .frameDone(fd_v[4]), .frameError(fe_v[4]), .wordCount(wc4), .overrun(ov_v[4]));

   // word entries: val = data, aux = index; frame entries: val = wordCount, aux = frameError
   typedef struct {
      int          inst;
      logic [31:0] val;
      int          aux;
   } exp_t;

   exp_t word_q[$];
   exp_t frame_q[$];

   int n_chk = 0;
   int n_err = 0;
   int samp_cyc = 0;
   int cs_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input int i, input logic [31:0] d, input int idx);
      exp_t e;
      e.inst = i; e.val = d; e.aux = idx;
      word_q.push_back(e);
   endtask

   task automatic push_frame(input int i, input int wcnt, input int ferr);
      exp_t e;
      e.inst = i; e.val = 32'(wcnt); e.aux = ferr;
      frame_q.push_back(e);
   endtask

   // scoreboard: compare every writeEnable / frameDone against the queued expectation
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < N; i++) begin
         if (we_v[i]) begin
            if (word_q.size() == 0) begin
               chk("spurious_we", 32'(we_v[i]), 32'd0);
            end else begin
               e = word_q.pop_front();
               chk("we_inst",    i, e.inst);
               chk("wdata",      wd_x[i], e.val);
               chk("windex",     wi_x[i], e.aux);
               chk("we_latency", cyc - samp_cyc, 3);
            end
         end
         if (fd_v[i]) begin
            chk("fd_we_excl", 32'(we_v[i]), 32'd0);
            if (frame_q.size() == 0) begin
               chk("spurious_fd", 32'(fd_v[i]), 32'd0);
            end else begin
               e = frame_q.pop_front();
               chk("fd_inst",    i, e.inst);
               chk("wordcount",  wc_x[i], e.val);
               chk("frameerror", 32'(fe_v[i]), e.aux);
               chk("fd_latency", cyc - cs_cyc, 4);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input int i, input logic b);
      logic cpol;
      logic lead;
      cpol = (cfg_mode[i] >= 2);
      lead = (cfg_mode[i] == 0) || (cfg_mode[i] == 2);
      if (lead) begin
         sdi_v[i] = b;
         tick(3);
         sck_v[i] = ~cpol;
         samp_cyc = cyc;
         tick(3);
         sck_v[i] = cpol;
      end else begin
         sck_v[i] = ~cpol;
         tick(1);
         sdi_v[i] = b;
         tick(3);
         sck_v[i] = cpol;
         samp_cyc = cyc;
         tick(3);
      end
   endtask

   task automatic send_word(input int i, input logic [31:0] w, input int nbits);
      for (int k = 0; k < nbits; k++) begin
         int bi;
         bi = (cfg_msb[i] != 0) ? (cfg_bits[i] - 1 - k) : k;
         send_bit(i, w[bi]);
      end
   endtask

   task automatic start_frame(input int i);
      cs_v[i] = (cfg_csh[i] != 0);
      tick(2);
      chk("busy_early", 32'(busy_v[i]), 32'd0);
      tick(1);
      chk("busy_rise", 32'(busy_v[i]), 32'd1);
      tick(2);
   endtask

   task automatic end_frame(input int i);
      tick(2);
      cs_v[i] = (cfg_csh[i] == 0);
      cs_cyc = cyc;
      tick(3);
      chk("busy_fall", 32'(busy_v[i]), 32'd0);
      tick(6);
   endtask

   logic seen_busy;

   initial begin
      for (int i = 0; i < N; i++) begin
         sck_v[i] = (cfg_mode[i] >= 2);
         cs_v[i]  = (cfg_csh[i] == 0);
         sdi_v[i] = 1'b0;
      end
      nrst_v = '0;
      tick(5);
      nrst_v = '1;
      tick(3);

      // reset state
      for (int i = 0; i < N; i++) begin
         chk("rst_busy",  32'(busy_v[i]), 32'd0);
         chk("rst_we",    32'(we_v[i]),   32'd0);
         chk("rst_wdata", wd_x[i],        32'd0);
         chk("rst_ovr",   32'(ov_v[i]),   32'd0);
      end
      chk("rst_windex", wi_x[0], 32'd0);
      chk("rst_wcount", wc_x[0], 32'd0);
      chk("rst_fd",     32'(fd_v[0]), 32'd0);
      chk("rst_fe",     32'(fe_v[0]), 32'd0);

      // mode 0 single word
      push_word(0, 32'hA5, 0);
      start_frame(0);
      send_word(0, 32'hA5, 8);
      push_frame(0, 1, 0);
      end_frame(0);

      // mode 3 LSB-first 16-bit burst
      push_word(1, 32'h1234, 0);
      push_word(1, 32'hBEEF, 1);
      push_word(1, 32'h00FF, 2);
      start_frame(1);
      send_word(1, 32'h1234, 16);
      send_word(1, 32'hBEEF, 16);
      send_word(1, 32'h00FF, 16);
      push_frame(1, 3, 0);
      end_frame(1);

      // mode 1 partial frame
      push_word(2, 32'h3C, 0);
      start_frame(2);
      send_word(2, 32'h3C, 8);
      send_word(2, 32'hB7, 5);
      push_frame(2, 1, 1);
      end_frame(2);

      // overrun with maxWords = 2
      push_word(3, 32'h11, 0);
      push_word(3, 32'h22, 1);
      start_frame(3);
      send_word(3, 32'h11, 8);
      send_word(3, 32'h22, 8);
      chk("ovr_before", 32'(ov_v[3]), 32'd0);
      send_word(3, 32'h33, 8);
      chk("ovr_set", 32'(ov_v[3]), 32'd1);
      push_frame(3, 2, 0);
      end_frame(3);
      chk("ovr_hold",   32'(ov_v[3]), 32'd1);
      chk("ovr_wdata",  wd_x[3], 32'h22);
      chk("ovr_windex", wi_x[3], 32'd1);
      start_frame(3);
      chk("ovr_clr", 32'(ov_v[3]), 32'd0);
      push_word(3, 32'h44, 0);
      send_word(3, 32'h44, 8);
      push_frame(3, 1, 0);
      end_frame(3);

      // reset mid-frame with cs held active
      start_frame(0);
      send_word(0, 32'hF0, 4);
      nrst_v[0] = 1'b0;
      tick(2);
      nrst_v[0] = 1'b1;
      chk("mrst_wdata",  wd_x[0], 32'd0);
      chk("mrst_we",     32'(we_v[0]), 32'd0);
      chk("mrst_windex", wi_x[0], 32'd0);
      chk("mrst_busy",   32'(busy_v[0]), 32'd0);
      chk("mrst_fd",     32'(fd_v[0]), 32'd0);
      chk("mrst_fe",     32'(fe_v[0]), 32'd0);
      chk("mrst_wcount", wc_x[0], 32'd0);
      chk("mrst_ovr",    32'(ov_v[0]), 32'd0);
      send_word(0, 32'hFF, 4);
      chk("mrst_idle", 32'(busy_v[0]), 32'd0);
      end_frame(0);
      push_word(0, 32'h5A, 0);
      start_frame(0);
      send_word(0, 32'h5A, 8);
      push_frame(0, 1, 0);
      end_frame(0);
      chk("post_rst_wdata", wd_x[0], 32'h5A);

      // active-low cs, mode 2
      push_word(4, 32'hC3, 0);
      start_frame(4);
      send_word(4, 32'hC3, 8);
      push_frame(4, 1, 0);
      end_frame(4);
      chk("csl_wdata", wd_x[4], 32'hC3);

      // sck activity with cs inactive must be ignored
      seen_busy = 1'b0;
      for (int k = 0; k < 16; k++) begin
         sck_v[4] = ~sck_v[4];
         tick(3);
         seen_busy = seen_busy | busy_v[4];
      end
      chk("idle_busy", 32'(seen_busy), 32'd0);

      tick(10);
      chk("words_pending",  word_q.size(),  0);
      chk("frames_pending", frame_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_burst_receiver.md
# spi_burst_receiver

Parametrised, oversampling SPI slave receiver for the edge-detection accelerator's MCU link. It samples `sck`, `sdi` and `cs` with a free-running `spiClk`, supports all four SPI modes, configurable word width and bit order, and accepts multi-word bursts per chip-select frame. It emits one `writeEnable` pulse per completed word and a frame summary at chip-select release, feeding the pixel/config write path.

## Interface
- `wordBits`, 8: bits per word, 2..32.
- `maxWords`, 4: words accepted per frame, ≥1.
- `spiMode`, 0: SPI mode 0..3. Modes 0 and 3 sample on rising `sck`; modes 1 and 2 sample on falling `sck`. CPOL = `spiMode[1]`.
- `msbFirst`, 1: 1 = first received bit lands in `writeData[wordBits-1]`; 0 = in bit 0.
- `csActiveHigh`, 1: polarity of `cs`.

Ports:
- Reset `nRst` is synchronous and active-low; the clock is `spiClk`.
- `spiClk`  in  1  free-running receiver clock, ≥4× `sck` frequency.
- `nRst`  in  1  synchronous active-low reset.
- `sck`  in  1  asynchronous SPI clock pin.
- `sdi`  in  1  asynchronous SPI data pin.
- `cs`  in  1  asynchronous chip select, polarity per `csActiveHigh`.
- `writeData`  out  `wordBits`  last completed word, held until the next word completes.
- `writeEnable`  out  1  one-cycle pulse per accepted word.
- `wordIndex`  out  max(1,$clog2(`maxWords`))  index of the word in `writeData`, 0-based within the frame.
- `busy`  out  1  high while in ACTIVE.
- `frameDone`  out  1  one-cycle pulse at frame end.
- `frameError`  out  1  one-cycle pulse with `frameDone` if the frame ended mid-word.
- `wordCount`  out  $clog2(`maxWords`+1)  accepted words in the finished frame, valid while `frameDone` is high and held afterwards.
- `overrun`  out  1  sticky flag for the current frame. Set when a word beyond `maxWords` completes. Cleared at the next frame start.

## Operation
- **Synchronisers:** `sck`, `sdi` and `cs` each pass through a 2-flop synchroniser plus a 1-flop delay stage used for edge detection.
  - Reset values: `sck` chain = CPOL idle level; `cs` chain = active level, so a `cs` held active through reset creates no start edge; `sdi` chain = 0.
- **Edge detection:**
  - sampleEdge: synchronised `sck` shows the mode's sampling transition.
  - csStart: synchronised `cs` goes inactive→active.
  - csEnd: synchronised `cs` goes active→inactive.
- **States:**
  - IDLE: on csStart, clear bit counter, word counter and `overrun`, then go to ACTIVE.
  - ACTIVE: on sampleEdge, shift synchronised `sdi` into the shift register (direction per `msbFirst`) and increment the bit counter.
    - When the bit counter reaches `wordBits`: load `writeData` and the word index, reset the bit counter, increment the word counter.
    - If the word counter was < `maxWords`, pulse `writeEnable`. Otherwise drop the word, hold `writeData`, set `overrun`.
    - On csEnd, go to DRAIN.
  - DRAIN: one cycle. Pulse `frameDone`; set `wordCount` = min(word counter, `maxWords`). Pulse `frameError` if the bit counter ≠ 0. Return to IDLE.
  - Any other encoding goes to IDLE.
- **Edges outside a frame:** sampleEdge in IDLE or DRAIN is ignored.
- **Simultaneous events:** if csEnd and sampleEdge occur in the same cycle, csEnd wins and the bit is discarded.
- **Reset:** `nRst` low mid-frame returns the block to IDLE with all outputs at reset values. The block ignores the remainder of that frame and needs a fresh csStart.
- **Counter widths:** counters saturate; the word counter stops at `maxWords`+1.

## Timing
- **Reset values:** `writeData` = 0, `writeEnable` = 0, `wordIndex` = 0, `busy` = 0, `frameDone` = 0, `frameError` = 0, `wordCount` = 0, `overrun` = 0.
- **Word latency:** for the final bit of a word, `sdi` must be stable before the sampling `sck` edge. `writeEnable`, `writeData` and `wordIndex` change on the 3rd rising `spiClk` edge after that `sck` edge.
- **Frame-end latency:** `frameDone` rises on the 4th rising `spiClk` edge after the `cs` deassert edge: 2 sync cycles + 1 detect cycle + 1 DRAIN cycle.
- **busy:** rises 3 `spiClk` cycles after the `cs` assert edge and falls with DRAIN entry.
- **Clocking constraints:** `sck` high and low phases must each be ≥2 `spiClk` periods. `cs` must be inactive ≥3 `spiClk` periods between frames.
- **Pulse rules:** `writeEnable` and `frameDone` are never high in the same cycle. Consecutive `writeEnable` pulses are ≥`2*wordBits` cycles apart.

## Test plan
- **Mode 0 single word** (defaults): one 8-bit frame of 0xA5 → one `writeEnable` with `writeData` = 0xA5 and `wordIndex` = 0; then `frameDone` = 1, `wordCount` = 1, `frameError` = 0.
- **Burst, LSB first** (`spiMode`=3, `msbFirst`=0, `wordBits`=16): frame of 0x1234, 0xBEEF, 0x00FF sent LSB first → three `writeEnable` pulses carrying 0x1234, 0xBEEF, 0x00FF with `wordIndex` 0, 1, 2; `wordCount` = 3.
- **Partial frame** (`spiMode`=1): 8 bits of 0x3C, then 5 bits, then `cs` released → one word 0x3C; `frameDone` with `frameError` = 1 and `wordCount` = 1.
- **Overrun** (`maxWords`=2): 3 words 0x11, 0x22, 0x33 → `writeEnable` only for 0x11 and 0x22; `writeData` stays 0x22; `overrun` = 1 until the next csStart; `wordCount` = 2.
- **Reset mid-frame:** `nRst` pulsed low after 4 bits while `cs` stays active → all outputs 0 and no activity for the rest of the frame; the next full frame with 0x5A yields `writeData` = 0x5A.
- **Active-low chip select** (`csActiveHigh`=0, `spiMode`=2): frame of 0xC3 → `writeData` = 0xC3. `sck` edges with `cs` inactive → no `writeEnable`, `busy` stays 0.
